// File: rtl/output_fill_ctrl_if.sv
// Handshake/bus bundle between the layer sequencer, the output FIFO, the BRAM
// write port and output_fill_ctrl.
interface output_fill_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int SIZE_W = 8,
  parameter int CH_W   = 2
);
  logic              start;
  logic              enable;
  logic [ADDR_W-1:0] base_addr;
  logic [SIZE_W-1:0] fmap_size;
  logic [ADDR_W-1:0] ch_stride;
  logic              src_empty;
  logic              src_rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CH_W-1:0]   ch_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, enable, base_addr, fmap_size, ch_stride, src_empty,
    input  src_rd_en, wr_en, wr_addr, ch_idx, busy, done
  );

  modport slave (
    input  start, enable, base_addr, fmap_size, ch_stride, src_empty,
    output src_rd_en, wr_en, wr_addr, ch_idx, busy, done
  );
endinterface

// File: rtl/output_fill_ctrl.sv
// Drains the PE-array output FIFO into the output feature-map BRAM, one
// channel of fmap_size words at a time, channels spaced ch_stride apart.
module output_fill_ctrl #(
  parameter int ADDR_W = 10,
  parameter int SIZE_W = 8,
  parameter int NUM_CH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               w_clk,
  input  logic               reset,
  output_fill_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [SIZE_W-1:0] size_q, word_cnt;
  logic [ADDR_W-1:0] stride_q, ch_base, rd_addr, wr_addr_q;
  logic [CH_W-1:0]   ch_cnt;
  logic              wr_en_q;
  logic              rd, last_word, last_ch;

  assign last_word = (word_cnt == size_q - SIZE_W'(1));
  assign last_ch   = (ch_cnt == CH_W'(NUM_CH - 1));

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) state_d = (bus.fmap_size == '0) ? DONE : RUN;
      RUN: begin
        rd = bus.enable & ~bus.src_empty;
        if (rd && last_word && last_ch) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // One-stage write pipeline: the FIFO word read this cycle lands in BRAM next cycle.
  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      size_q    <= '0;
      stride_q  <= '0;
      ch_base   <= '0;
      rd_addr   <= '0;
      word_cnt  <= '0;
      ch_cnt    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q <= rd;
      if (rd) wr_addr_q <= rd_addr;
      if (state_q == IDLE && bus.start) begin
        size_q   <= bus.fmap_size;
        stride_q <= bus.ch_stride;
        ch_base  <= bus.base_addr;
        rd_addr  <= bus.base_addr;
        word_cnt <= '0;
        ch_cnt   <= '0;
      end else if (rd) begin
        if (last_word) begin
          word_cnt <= '0;
          ch_base  <= ch_base + stride_q;
          rd_addr  <= ch_base + stride_q;
          // Hold on the final channel so ch_idx never exceeds NUM_CH-1.
          if (!last_ch) ch_cnt <= ch_cnt + CH_W'(1);
        end else begin
          word_cnt <= word_cnt + SIZE_W'(1);
          rd_addr  <= rd_addr + ADDR_W'(1);
        end
      end
    end
  end

  assign bus.src_rd_en = rd;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.ch_idx    = ch_cnt;
  assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_output_fill_ctrl.sv
// Directed bench for output_fill_ctrl: a read-count/address-list model checked
// every cycle, plus literal address and latency expectations per scenario.
module tb_output_fill_ctrl;
  localparam int ADDR_W = 10;
  localparam int SIZE_W = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic w_clk = 1'b0;
  logic reset = 1'b0;
  always #5 w_clk = ~w_clk;

  output_fill_ctrl_if #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .CH_W(CH_W)) bus ();

  output_fill_ctrl #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .NUM_CH(NUM_CH)) dut (
    .w_clk (w_clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Model: expectations for the current cycle, advanced at each negedge.
  bit          m_busy = 0, m_done = 0, m_wr = 0;
  logic [9:0]  m_waddr = '0;
  logic [9:0]  m_base = '0, m_stride = '0;
  int          m_size = 0, m_nrd = 0, m_total = 0;
  int          start_cyc = -1, last_rd_cyc = -1, done_cyc = -1;
  logic [9:0]  wlog[$];

  logic [9:0] exp1 [12] = '{10'h010, 10'h011, 10'h012, 10'h018, 10'h019, 10'h01A,
                            10'h020, 10'h021, 10'h022, 10'h028, 10'h029, 10'h02A};
  logic [9:0] expw [5]  = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002};

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [9:0] addr_of(input int n);
    int a;
    a = int'(m_base) + (n / m_size) * int'(m_stride) + (n % m_size);
    return a[9:0];
  endfunction

  always @(negedge w_clk) begin
    bit exp_rd, drain;
    int exp_ch;
    if (reset) begin
      exp_rd = m_busy && (m_nrd < m_total) && bus.enable && !bus.src_empty;
      chk("src_rd_en", int'(bus.src_rd_en), int'(exp_rd));
      chk("wr_en", int'(bus.wr_en), int'(m_wr));
      if (m_wr) chk("wr_addr", int'(bus.wr_addr), int'(m_waddr));
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("done", int'(bus.done), int'(m_done));
      if (m_busy) begin
        exp_ch = m_nrd / m_size;
        if (exp_ch > NUM_CH - 1) exp_ch = NUM_CH - 1;
        chk("ch_idx", int'(bus.ch_idx), exp_ch);
      end
      if (bus.wr_en) wlog.push_back(bus.wr_addr);
      if (bus.done) done_cyc = cyc;
      if (exp_rd) last_rd_cyc = cyc;

      drain = m_busy && (m_nrd == m_total);
      m_wr  = exp_rd;
      if (exp_rd) begin
        m_waddr = addr_of(m_nrd);
        m_nrd++;
      end
      if (m_done) m_done = 0;
      else if (drain) begin
        m_busy = 0;
        m_done = 1;
      end else if (!m_busy && bus.start) begin
        m_base    = bus.base_addr;
        m_stride  = bus.ch_stride;
        m_size    = int'(bus.fmap_size);
        m_nrd     = 0;
        m_total   = NUM_CH * m_size;
        start_cyc = cyc;
        if (m_size == 0) m_done = 1;
        else             m_busy = 1;
      end
    end
    cyc++;
  end

  task automatic do_start(input logic [9:0] b, input int s, input logic [9:0] st);
    wlog.delete();
    done_cyc = -1;
    @(posedge w_clk); #1;
    bus.base_addr = b;
    bus.fmap_size = SIZE_W'(s);
    bus.ch_stride = st;
    bus.start     = 1'b1;
    @(posedge w_clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    for (int i = 0; i < 200; i++) begin
      @(posedge w_clk); #1;
      if (done_cyc >= 0) break;
      if (toggle) bus.src_empty = ~bus.src_empty;
    end
    bus.src_empty = 1'b0;
    chk("done_timeout", int'(done_cyc >= 0), 1);
    repeat (2) @(posedge w_clk);
    #1;
  endtask

  task automatic chk_list12(input string name);
    chk({name, "_count"}, wlog.size(), 12);
    for (int i = 0; i < 12 && i < wlog.size(); i++)
      chk(name, int'(wlog[i]), int'(exp1[i]));
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_wr_en"}, int'(bus.wr_en), 0);
    chk({name, "_wr_addr"}, int'(bus.wr_addr), 0);
    chk({name, "_busy"}, int'(bus.busy), 0);
    chk({name, "_done"}, int'(bus.done), 0);
    chk({name, "_ch_idx"}, int'(bus.ch_idx), 0);
    chk({name, "_rd_en"}, int'(bus.src_rd_en), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.enable    = 1'b1;
    bus.src_empty = 1'b0;
    bus.base_addr = '0;
    bus.fmap_size = '0;
    bus.ch_stride = '0;
    repeat (3) @(posedge w_clk);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b1;

    // Basic run
    do_start(10'h010, 3, 10'h008);
    wait_done(1'b0);
    chk_list12("basic_addr");
    chk("basic_done_lat", done_cyc - last_rd_cyc, 2);
    chk("basic_start_to_done", done_cyc - start_cyc, 14);

    // FIFO back-pressure
    do_start(10'h010, 3, 10'h008);
    bus.src_empty = 1'b1;
    wait_done(1'b1);
    chk_list12("bp_addr");
    chk("bp_done_lat", done_cyc - last_rd_cyc, 2);

    // Stall mid-channel 1 with a stray start while running
    do_start(10'h010, 3, 10'h008);
    repeat (4) @(posedge w_clk);
    #1;
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.start     = (i == 2);
      bus.base_addr = 10'h100;
      @(posedge w_clk); #1;
    end
    bus.start  = 1'b0;
    bus.enable = 1'b1;
    wait_done(1'b0);
    chk_list12("stall_addr");

    // Address wrap
    do_start(10'h3FE, 4, 10'h004);
    wait_done(1'b0);
    chk("wrap_count", wlog.size(), 16);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      chk("wrap_addr", int'(wlog[i]), int'(expw[i]));

    // Zero size
    do_start(10'h050, 0, 10'h008);
    wait_done(1'b0);
    chk("zero_done_lat", done_cyc - start_cyc, 1);
    chk("zero_writes", wlog.size(), 0);

    // Reset after the 5th read, write in flight
    do_start(10'h010, 3, 10'h008);
    repeat (5) @(posedge w_clk);
    #2;
    chk("pre_reset_wr_en", int'(bus.wr_en), 1);
    reset  = 1'b0;
    m_busy = 0; m_done = 0; m_wr = 0; m_nrd = 0; m_total = 0;
    #1;
    chk_zero_outputs("async_reset");
    repeat (2) @(posedge w_clk);
    #1;
    reset    = 1'b1;
    done_cyc = -1;
    repeat (4) @(posedge w_clk);
    #1;
    chk("no_done_after_reset", done_cyc, -1);
    do_start(10'h200, 2, 10'h010);
    wait_done(1'b0);
    chk("restart_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("restart_addr0", int'(wlog[0]), 10'h200);
      chk("restart_addr2", int'(wlog[2]), 10'h210);
      chk("restart_addr7", int'(wlog[7]), 10'h231);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
